// File: rtl/instr_prefetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | instr_prefetch : byte-wide sequential instruction prefetcher with FWFT FIFO |
// | Option macro   : PREFETCH_ADDR_TAG_EN (tags each byte with its address)     |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module instr_prefetch #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [7:0]               memAddr,
  output logic                     memStrobe,
  input  logic [7:0]               memDataRead,
  input  logic                     redirect,
  input  logic [7:0]               redirectAddr,
  output logic                     byteValid,
  output logic [7:0]               byteData,
  input  logic                     byteTake,
`ifdef PREFETCH_ADDR_TAG_EN
  output logic [7:0]               byteAddr,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW:0] DEPTH_OCC = (LW+1)'(DEPTH);
`ifdef PREFETCH_ADDR_TAG_EN
  localparam int FW = 16;
`else
  localparam int FW = 8;
`endif

  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [FW-1:0] fifo_q [DEPTH];
  logic [FW-1:0] fifo_d [DEPTH];
  logic [FW-1:0] entry;
  logic [LW:0]   occupancy;
  logic          push, pop, non_empty;
`ifdef PREFETCH_ADDR_TAG_EN
  logic [7:0]    inflight_addr_q, inflight_addr_d;
`endif

  // The in-flight read is counted as occupied so a returning byte always has room.
  assign occupancy = {1'b0, count_q} + {{LW{1'b0}}, inflight_q};
  assign non_empty = (count_q != '0);

  assign memAddr   = fetch_pc_q;
  assign memStrobe = ~reset & ~redirect & (occupancy < DEPTH_OCC);
  assign byteValid = ~reset & non_empty;
  assign level     = reset ? '0 : count_q;
  assign byteData  = fifo_q[rd_ptr_q][7:0];

  assign push = inflight_q;
  assign pop  = non_empty & byteTake;

`ifdef PREFETCH_ADDR_TAG_EN
  assign entry    = {inflight_addr_q, memDataRead};
  assign byteAddr = byteValid ? fifo_q[rd_ptr_q][15:8] : 8'h00;
`else
  assign entry    = memDataRead;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fifo_d     = fifo_q;
`ifdef PREFETCH_ADDR_TAG_EN
    inflight_addr_d = inflight_addr_q;
`endif
    if (redirect) begin
      fetch_pc_d = redirectAddr;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (memStrobe) begin
        fetch_pc_d = fetch_pc_q + 8'd1;
        inflight_d = 1'b1;
`ifdef PREFETCH_ADDR_TAG_EN
        inflight_addr_d = fetch_pc_q;
`endif
      end
      if (push) begin
        fifo_d[wr_ptr_q] = entry;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
`ifdef PREFETCH_ADDR_TAG_EN
      inflight_addr_q <= 8'h00;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
`ifdef PREFETCH_ADDR_TAG_EN
      inflight_addr_q <= inflight_addr_d;
`endif
    end
  end

  // Storage needs no reset: entries are only read once count marks them valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_instr_prefetch : queue-based reference model bench for instr_prefetch    |
// | Revision          : 1.0                                                     |
// +-----------------------------------------------------------------------------+
module tb_instr_prefetch;

  localparam int         DEPTH    = 4;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk = 1'b0;
  logic       reset, redirect, byteTake;
  logic [7:0] redirectAddr, memDataRead, memAddr, byteData;
  logic       memStrobe, byteValid;
  logic [2:0] level;
`ifdef PREFETCH_ADDR_TAG_EN
  logic [7:0] byteAddr;
`endif

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .memAddr      (memAddr),
    .memStrobe    (memStrobe),
    .memDataRead  (memDataRead),
    .redirect     (redirect),
    .redirectAddr (redirectAddr),
    .byteValid    (byteValid),
    .byteData     (byteData),
    .byteTake     (byteTake),
`ifdef PREFETCH_ADDR_TAG_EN
    .byteAddr     (byteAddr),
`endif
    .level        (level)
  );

  // Synchronous program memory: data for a strobed address appears next cycle.
  logic [7:0] mem [256];
  always @(posedge clk) if (memStrobe) memDataRead <= mem[memAddr];

  // Reference model: buffered {addr,data} bytes, next fetch address, pending read.
  logic [15:0] mq[$];
  logic [7:0]  m_pc;
  bit          m_infl;
  logic [7:0]  m_infl_addr;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [7:0] ra, input logic tk);
    bit ev, es;
    @(negedge clk);
    reset = r; redirect = rd; redirectAddr = ra; byteTake = tk;
    #1;
    ev = !r && (mq.size() != 0);
    es = !r && !rd && ((mq.size() + int'(m_infl)) < DEPTH);
    chk("memStrobe", {7'b0, memStrobe}, {7'b0, es});
    chk("memAddr",   memAddr, m_pc);
    chk("byteValid", {7'b0, byteValid}, {7'b0, ev});
    chk("level",     {5'b0, level}, r ? 8'd0 : 8'(mq.size()));
    if (ev) begin
      chk("byteData", byteData, mq[0][7:0]);
`ifdef PREFETCH_ADDR_TAG_EN
      chk("byteAddr", byteAddr, mq[0][15:8]);
`endif
    end
`ifdef PREFETCH_ADDR_TAG_EN
    else chk("byteAddr_empty", byteAddr, 8'h00);
`endif
    @(posedge clk);
    if (r) begin
      mq.delete(); m_pc = RESET_PC; m_infl = 0;
    end else if (rd) begin
      mq.delete(); m_pc = ra; m_infl = 0;
    end else begin
      if (ev && tk) void'(mq.pop_front());
      if (m_infl) mq.push_back({m_infl_addr, mem[m_infl_addr]});
      if (es) begin
        m_infl_addr = m_pc;
        m_pc        = m_pc + 8'd1;
        m_infl      = 1;
      end else begin
        m_infl = 0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirectAddr = 8'h00; byteTake = 1'b0;
    m_pc = RESET_PC; m_infl = 0; m_infl_addr = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    @(posedge clk);

    // Reset release with byteTake held: sequential bytes one per cycle.
    step(1, 0, 8'h00, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 8'h00, 1);

    // No consumption: fill to DEPTH and stall, then a single take.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);

    // Redirect while a read is in flight and two bytes are buffered.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
    step(0, 1, 8'h40, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1);

    // Address wrap FF -> 00.
    step(0, 1, 8'hFE, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1);

    // Redirect with a concurrent take, then a one-cycle reset mid-fill.
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h80, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
    step(1, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1);

    // Back-to-back redirects: the last one wins.
    step(0, 1, 8'h10, 1);
    step(0, 1, 8'h20, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);

    // Randomized traffic; memory contents only change under reset.
    for (int i = 0; i < 600; i++) begin
      logic r, rd, tk;
      logic [7:0] ra;
      if (i % 150 == 0) begin
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        r = 1'b1;
      end else begin
        r = ($urandom_range(0, 49) == 0);
      end
      rd = ($urandom_range(0, 19) == 0);
      tk = ($urandom_range(0, 9) < 7);
      ra = 8'($urandom);
      step(r, rd, ra, tk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
